// File: rtl/sign_ext_mpy_pkg.sv
// Shared definitions for the sequential signed shift-and-add multiplier.
package sign_ext_mpy_pkg;

  localparam int unsigned N      = 4;
  localparam int unsigned P_W    = 2 * N;
  localparam int unsigned STEP_W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [P_W-1:0] sext(input logic [N-1:0] v);
    return {{N{v[N-1]}}, v};
  endfunction

endpackage

// File: rtl/sign_ext_mpy_if.sv
// Operand/result bundle: the master drives operands, the slave returns the product.
interface sign_ext_mpy_if;
  import sign_ext_mpy_pkg::*;

  logic signed [N-1:0]   a;
  logic signed [N-1:0]   b;
  logic signed [P_W-1:0] product;
  logic                  done;

  modport master (output a, output b, input product, input done);
  modport slave  (input a, input b, output product, output done);

endinterface

// File: rtl/sign_ext_mpy_pp_gen.sv
// Combinational partial-product generator: sign-extended, shifted multiplicand.
module sign_ext_pp_gen
  import sign_ext_mpy_pkg::*;
(
  input  logic [N-1:0]      i_a,
  input  logic              i_b_bit,
  input  logic [STEP_W-1:0] i_step,
  output logic [P_W-1:0]    o_pp,
  output logic              o_sub
);

  logic [P_W-1:0] w_ext;

  assign w_ext = sext(i_a);
  assign o_pp  = i_b_bit ? (w_ext << i_step) : '0;
  // The multiplier MSB carries negative weight in two's complement.
  assign o_sub = (i_step == STEP_W'(N - 1));

endmodule

// File: rtl/sign_ext_mpy.sv
// Free-running signed multiplier; restarts whenever the operands differ from the latched pair.
module sign_ext_mpy
  import sign_ext_mpy_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  sign_ext_mpy_if.slave bus
);

  state_t              r_state, w_next;
  logic [N-1:0]        r_a, r_b;
  logic [P_W-1:0]      r_acc, r_product;
  logic [STEP_W-1:0]   r_step;
  logic                r_restart, r_done;
  logic                w_restart, w_b_bit, w_sub;
  logic [P_W-1:0]      w_pp;

  assign w_restart = r_restart || (bus.a != r_a) || (bus.b != r_b);
  assign w_b_bit   = r_b[r_step];

  sign_ext_pp_gen u_pp_gen (
    .i_a     (r_a),
    .i_b_bit (w_b_bit),
    .i_step  (r_step),
    .o_pp    (w_pp),
    .o_sub   (w_sub)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_restart) begin
      w_next = CALC;
    end else begin
      case (r_state)
        CALC:    if (r_step == STEP_W'(N - 1)) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_step    <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
      r_restart <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (w_restart) begin
        r_a       <= bus.a;
        r_b       <= bus.b;
        r_acc     <= '0;
        r_step    <= '0;
        r_restart <= 1'b0;
      end else if (r_state == CALC) begin
        r_acc  <= w_sub ? (r_acc - w_pp) : (r_acc + w_pp);
        r_step <= r_step + 1'b1;
      end else if (r_state == DONE) begin
        r_product <= r_acc;
        r_done    <= 1'b1;
      end
    end
  end

  assign bus.product = r_product;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_sign_ext_mpy.sv
// Self-checking bench for sign_ext_mpy: cycle model plus directed literal expectations.
module tb_sign_ext_mpy;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sign_ext_mpy_if bus();

  sign_ext_mpy dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a new operand pair starts a computation; result appears 5 edges later.
  logic signed [3:0] m_a = '0, m_b = '0;
  logic signed [7:0] m_prod = '0;
  logic              m_done = 1'b0;
  logic              m_fresh = 1'b1;
  int                m_age = 5;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a = '0; m_b = '0; m_prod = '0; m_done = 1'b0; m_fresh = 1'b1; m_age = 5;
    end else begin
      m_done = 1'b0;
      if (m_fresh || bus.a != m_a || bus.b != m_b) begin
        m_a = bus.a; m_b = bus.b; m_fresh = 1'b0; m_age = 0;
      end else if (m_age < 4) begin
        m_age++;
      end else if (m_age == 4) begin
        m_prod = 8'(int'(m_a) * int'(m_b));
        m_done = 1'b1;
        m_age  = 5;
      end
    end
  end

  int done_cnt = 0;
  int cnt15    = 0;

  always @(negedge clk) begin
    checks++;
    if (bus.product !== m_prod || bus.done !== m_done) begin
      errors++;
      $display("FAIL model t=%0t product=%0d done=%b required product=%0d done=%b",
               $time, bus.product, bus.done, m_prod, m_done);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.product === 8'sd15) cnt15++;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, $signed(got), $signed(exp));
    end
  endtask

  task automatic apply(input int av, input int bv);
    @(posedge clk);
    #2;
    bus.a = 4'(av);
    bus.b = 4'(bv);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  int base_d, base15;

  initial begin
    bus.a = '0;
    bus.b = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product", 8'(bus.product), 8'd0);
    chk("reset_done", {7'd0, bus.done}, 8'd0);

    // 7*7 from reset, held 16 cycles
    base_d = done_cnt;
    #1 rst = 1'b0;
    bus.a = 4'sd7; bus.b = 4'sd7;
    settle(6);
    chk("p_7x7_latency", 8'(bus.product), 8'd49);
    settle(10);
    chk("p_7x7_hold", 8'(bus.product), 8'd49);
    chk("done_7x7", 8'(done_cnt - base_d), 8'd1);

    apply(-8, -8); settle(7); chk("p_m8xm8", 8'(bus.product), 8'd64);
    apply(-8,  7); settle(7); chk("p_m8x7",  8'(bus.product), 8'(-56));
    apply( 7, -8); settle(7); chk("p_7xm8",  8'(bus.product), 8'(-56));
    apply(-1, -1); settle(7); chk("p_m1xm1", 8'(bus.product), 8'd1);
    apply( 0, -5); settle(7); chk("p_0xm5",  8'(bus.product), 8'd0);
    apply(-3,  5); settle(7); chk("p_m3x5",  8'(bus.product), 8'(-15));

    for (int ia = -8; ia < 8; ia++) begin
      for (int ib = -8; ib < 8; ib++) begin
        apply(ia, ib);
        settle(15);
        chk("sweep", 8'(bus.product), 8'(ia * ib));
      end
    end

    // abort: a changes from 3 to -6 two cycles into CALC
    base_d = done_cnt; base15 = cnt15;
    apply(3, 5);
    repeat (3) @(posedge clk);
    #2 bus.a = -4'sd6;
    settle(10);
    chk("abort_product", 8'(bus.product), 8'(-30));
    chk("abort_done_cnt", 8'(done_cnt - base_d), 8'd1);
    chk("abort_no_15", 8'(cnt15 - base15), 8'd0);

    // reset mid-CALC
    apply(5, -4);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_product", 8'(bus.product), 8'd0);
    chk("rst_mid_done", {7'd0, bus.done}, 8'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    settle(6);
    chk("rst_after_product", 8'(bus.product), 8'(-20));

    // hold 2*3 for 50 cycles
    apply(2, 3);
    base_d = done_cnt;
    settle(50);
    chk("hold_product", 8'(bus.product), 8'd6);
    chk("hold_done_cnt", 8'(done_cnt - base_d), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
